// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, mux codes
// and the raw control vector. No logic, no latency, no stall behaviour.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  localparam logic [2:0] OP_RTYPE   = 3'd0;
  localparam logic [2:0] OP_ADDI    = 3'd1;
  localparam logic [2:0] OP_LW      = 3'd2;
  localparam logic [2:0] OP_SW      = 3'd3;
  localparam logic [2:0] OP_BEQ     = 3'd4;
  localparam logic [2:0] OP_J       = 3'd5;
  localparam logic [2:0] OP_ILLEGAL = 3'd6;
  localparam logic [2:0] OP_HALT    = 3'd7;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: state -> raw (ungated) control vector, purely combinational.
// Stall gating is applied by the caller; unknown encodings decode like IDLE (all zero).
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_BOFF;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.ior_d  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_wr = 1'b1;
        ctrl.ior_d  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_ADDIWB: ctrl.reg_wr = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: 3-5 cycles per instruction, Moore outputs valid all cycle.
// Stall holds state/counters and masks every write strobe; selects stay at their state values.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [2:0]       OpCode,
  input  logic             Zero,
  input  logic             Stall,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRD,
  output logic             MemWR,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWR,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Halted,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  ctrl_t            raw;

  mips_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (raw)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_DECODE;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DECODE: begin
        case (OpCode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ILLEGAL: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      // Unreachable encodings behave like IDLE.
      default:  state_d = S_FETCH;
    endcase
    if (Stall) begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign PCWrite     = raw.pc_write      & ~Stall;
  assign PCWriteCond = raw.pc_write_cond & ~Stall;
  assign MemWR       = raw.mem_wr        & ~Stall;
  assign IRWrite     = raw.ir_write      & ~Stall;
  assign RegWR       = raw.reg_wr        & ~Stall;
  assign PCEn        = PCWrite | (PCWriteCond & Zero);

  assign IorD       = raw.ior_d;
  assign MemRD      = raw.mem_rd;
  assign MemtoReg   = raw.mem_to_reg;
  assign RegDst     = raw.reg_dst;
  assign ALUSrcA    = raw.alu_src_a;
  assign ALUSrcB    = raw.alu_src_b;
  assign ALUOp      = raw.alu_op;
  assign PCSource   = raw.pc_source;
  assign State      = state_q;
  assign Halted     = (state_q == S_HALT);
  assign Illegal    = illegal_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control; a CNT_W=3 twin shares the inputs to show counter wrap.
module tb_mips_multicycle_control;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [2:0]  OpCode = 3'd0;
  logic        Zero = 1'b0;
  logic        Stall = 1'b0;
  logic        PCWrite, PCWriteCond, PCEn, IorD, MemRD, MemWR, IRWrite;
  logic        MemtoReg, RegDst, RegWR, ALUSrcA, Halted, Illegal;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  State;
  logic [15:0] InstrCount;

  logic        w_pcw, w_pcwc, w_pcen, w_iord, w_mrd, w_mwr, w_irw;
  logic        w_m2r, w_rdst, w_rwr, w_srca, w_halt, w_ill;
  logic [1:0]  w_srcb, w_aop, w_psrc;
  logic [3:0]  w_st;
  logic [2:0]  cnt3;

  logic [16:0] obs;
  assign obs = {PCWrite, PCWriteCond, PCEn, IorD, MemRD, MemWR, IRWrite, MemtoReg,
                RegDst, RegWR, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  mips_multicycle_control #(.CNT_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .OpCode(OpCode), .Zero(Zero), .Stall(Stall),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemRD(MemRD), .MemWR(MemWR), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWR(RegWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .Halted(Halted),
    .Illegal(Illegal), .InstrCount(InstrCount)
  );

  mips_multicycle_control #(.CNT_W(3)) dut_w (
    .Clock(Clock), .Reset_n(Reset_n), .OpCode(OpCode), .Zero(Zero), .Stall(Stall),
    .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .PCEn(w_pcen), .IorD(w_iord),
    .MemRD(w_mrd), .MemWR(w_mwr), .IRWrite(w_irw), .MemtoReg(w_m2r),
    .RegDst(w_rdst), .RegWR(w_rwr), .ALUSrcA(w_srca), .ALUSrcB(w_srcb),
    .ALUOp(w_aop), .PCSource(w_psrc), .State(w_st), .Halted(w_halt),
    .Illegal(w_ill), .InstrCount(cnt3)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  st;
    logic        stl;
    logic        z;
    logic [16:0] ctl;
    logic [15:0] cnt;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_ill = 1'b0;
  logic [3:0]  last_st = 4'd0;
  logic        last_stl = 1'b0;

  // Expected control vector, written from the per-state output table.
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic stl, input logic z);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd1:        begin mrd = 1; irw = 1; pcw = 1; srcb = 2'b01; end
      4'd2:        srcb = 2'b11;
      4'd3, 4'd11: begin srca = 1; srcb = 2'b10; end
      4'd4:        begin mrd = 1; iord = 1; end
      4'd5:        begin rwr = 1; m2r = 1; end
      4'd6:        begin mwr = 1; iord = 1; end
      4'd7:        begin srca = 1; aop = 2'b10; end
      4'd8:        begin rwr = 1; rdst = 1; end
      4'd9:        begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      4'd10:       begin pcw = 1; psrc = 2'b10; end
      4'd12:       rwr = 1;
      default:     ;
    endcase
    if (stl) begin pcw = 0; pcwc = 0; mwr = 0; irw = 0; rwr = 0; end
    return {pcw, pcwc, pcw | (pcwc & z), iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, psrc};
  endfunction

  task automatic push(input logic [3:0] st, input logic stl, input logic z);
    exp_t e;
    if (last_st == 4'd1 && !last_stl) m_cnt = m_cnt + 16'd1;
    if (last_st == 4'd2 && !last_stl && OpCode == 3'd6) m_ill = 1'b1;
    e.st = st; e.stl = stl; e.z = z; e.ctl = exp_ctl(st, stl, z);
    e.cnt = m_cnt; e.ill = m_ill;
    sb.push_back(e);
    last_st = st; last_stl = stl;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; OpCode = 3'd0; Stall = 1'b0; Zero = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (State !== 4'd0 || obs !== 17'd0 || InstrCount !== 16'd0 || Illegal !== 1'b0 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d ctl=%h cnt=%0d ill=%b halt=%b, want all zero", State, obs, InstrCount, Illegal, Halted);
    end
    Reset_n = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL reset_release: state=%0d want 0", State); end
  endtask

  task automatic test_rtype();
    exp_t e;
    OpCode = 3'd0;
    push(4'd1, 0, 0); push(4'd2, 0, 0); push(4'd7, 0, 0); push(4'd8, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge Clock); #1; Stall = e.stl; Zero = e.z;
      @(negedge Clock);
      checks++; if (State !== e.st) begin errors++; $display("FAIL rtype state: got %0d want %0d", State, e.st); end
      checks++; if (obs !== e.ctl) begin errors++; $display("FAIL rtype ctl in st%0d: got %h want %h", e.st, obs, e.ctl); end
      checks++; if (InstrCount !== e.cnt || cnt3 !== e.cnt[2:0]) begin errors++; $display("FAIL rtype cnt: got %0d/%0d want %0d", InstrCount, cnt3, e.cnt); end
    end
  endtask

  task automatic test_lw();
    exp_t e;
    OpCode = 3'd2;
    push(4'd1, 0, 0); push(4'd2, 0, 0); push(4'd3, 0, 0); push(4'd4, 0, 0); push(4'd5, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge Clock); #1; Stall = e.stl; Zero = e.z;
      @(negedge Clock);
      checks++; if (State !== e.st) begin errors++; $display("FAIL lw state: got %0d want %0d", State, e.st); end
      checks++; if (obs !== e.ctl) begin errors++; $display("FAIL lw ctl in st%0d: got %h want %h", e.st, obs, e.ctl); end
      checks++; if (InstrCount !== e.cnt) begin errors++; $display("FAIL lw cnt: got %0d want %0d", InstrCount, e.cnt); end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    OpCode = 3'd4;
    push(4'd1, 0, 1); push(4'd2, 0, 1); push(4'd9, 0, 1);
    push(4'd1, 0, 0); push(4'd2, 0, 0); push(4'd9, 0, 0);
    push(4'd1, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge Clock); #1; Stall = e.stl; Zero = e.z;
      @(negedge Clock);
      checks++; if (State !== e.st) begin errors++; $display("FAIL beq state: got %0d want %0d", State, e.st); end
      checks++; if (obs !== e.ctl) begin errors++; $display("FAIL beq ctl in st%0d zero=%b: got %h want %h", e.st, e.z, obs, e.ctl); end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    OpCode = 3'd3;
    push(4'd2, 0, 0); push(4'd3, 0, 0);
    push(4'd6, 1, 0); push(4'd6, 1, 0); push(4'd6, 1, 0);
    push(4'd6, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge Clock); #1; Stall = e.stl; Zero = e.z;
      @(negedge Clock);
      checks++; if (State !== e.st) begin errors++; $display("FAIL stall state: got %0d want %0d", State, e.st); end
      checks++; if (obs !== e.ctl) begin errors++; $display("FAIL stall ctl st%0d stall=%b: got %h want %h", e.st, e.stl, obs, e.ctl); end
      checks++; if (InstrCount !== e.cnt) begin errors++; $display("FAIL stall cnt: got %0d want %0d", InstrCount, e.cnt); end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    OpCode = 3'd6;
    push(4'd1, 0, 0); push(4'd2, 0, 0);
    for (int i = 0; i < 11; i++) push(4'd13, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge Clock); #1; Stall = e.stl; Zero = e.z;
      @(negedge Clock);
      checks++; if (State !== e.st) begin errors++; $display("FAIL illegal state: got %0d want %0d", State, e.st); end
      checks++; if (obs !== e.ctl) begin errors++; $display("FAIL illegal ctl st%0d: got %h want %h", e.st, obs, e.ctl); end
      checks++;
      if (Illegal !== e.ill || Halted !== (e.st == 4'd13)) begin
        errors++;
        $display("FAIL illegal flags: ill=%b halt=%b want ill=%b halt=%b", Illegal, Halted, e.ill, (e.st == 4'd13));
      end
    end
    @(negedge Clock);
    Reset_n = 1'b0;
    #2;
    checks++;
    if (State !== 4'd0 || Illegal !== 1'b0 || Halted !== 1'b0 || InstrCount !== 16'd0 || obs !== 17'd0) begin
      errors++;
      $display("FAIL halt_reset: state=%0d ill=%b halt=%b cnt=%0d ctl=%h want all zero", State, Illegal, Halted, InstrCount, obs);
    end
    m_cnt = 16'd0; m_ill = 1'b0; last_st = 4'd0; last_stl = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    exp_t e;
    OpCode = 3'd5;
    for (int i = 0; i < 9; i++) begin
      push(4'd1, 0, 0); push(4'd2, 0, 0); push(4'd10, 0, 0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge Clock); #1; Stall = e.stl; Zero = e.z;
      @(negedge Clock);
      checks++; if (State !== e.st) begin errors++; $display("FAIL jwrap state: got %0d want %0d", State, e.st); end
      checks++; if (obs !== e.ctl) begin errors++; $display("FAIL jwrap ctl st%0d: got %h want %h", e.st, obs, e.ctl); end
      checks++;
      if (InstrCount !== e.cnt || cnt3 !== e.cnt[2:0]) begin
        errors++;
        $display("FAIL jwrap cnt: got %0d narrow %0d want %0d narrow %0d", InstrCount, cnt3, e.cnt, e.cnt[2:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_branch();
    test_stall();
    test_illegal();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
